// File: rtl/aes_spi_pkg.sv
// Shared types and default geometry for the AES SPI slave.
package aes_spi_pkg;

  localparam int unsigned NB_DEFAULT = 4;
  localparam int unsigned NK_DEFAULT = 4;
  localparam int unsigned FRAME_BITS = 32 * (NB_DEFAULT + NK_DEFAULT);
  // One start bit followed by the result block.
  localparam int unsigned TX_BITS    = 32 * NB_DEFAULT + 1;

  typedef enum logic [2:0] {
    StIdle,
    StRx,
    StHand,
    StWait,
    StTx
  } state_e;

endpackage

// File: rtl/aes_spi_slave_shift_reg.sv
// MSB-first shift register with clear, parallel load and serial shift-in.
module spi_shift_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [Width-1:0] din,
  input  logic             shift,
  input  logic             sin,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= din;
    end else if (shift) begin
      q_q <= {q_q[Width-2:0], sin};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/aes_spi_slave.sv
// SPI-style slave: receives a message/key frame, hands it to the AES core, returns the result.
module aes_spi_slave
  import aes_spi_pkg::*;
#(
  parameter int unsigned nb = NB_DEFAULT,
  parameter int unsigned nk = NK_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs,
  input  logic            Mosi,
  output logic            Miso,
  output logic            blk_valid,
  input  logic            blk_ready,
  output logic [32*nb-1:0] msg_out,
  output logic [32*nk-1:0] key_out,
  input  logic            res_valid,
  input  logic [32*nb-1:0] res_data,
  output logic            res_ready,
  output logic            busy,
  output logic            done,
  output logic            frame_err
);

  localparam int unsigned BlkBits   = 32 * nb;
  localparam int unsigned KeyBits   = 32 * nk;
  localparam int unsigned FrameBits = BlkBits + KeyBits;
  localparam int unsigned CntW      = $clog2(FrameBits) + 1;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                miso_q, miso_d;
  logic                done_q, done_d;
  logic                ferr_q, ferr_d;
  logic                armed_q, armed_d;
  logic [BlkBits-1:0]  msg_q, msg_d;
  logic [KeyBits-1:0]  key_q, key_d;

  logic                rx_clr, rx_load, rx_shift;
  logic                tx_clr, tx_load, tx_shift;
  logic [FrameBits-2:0] rx_q;
  logic [BlkBits-1:0]  tx_q;
  logic [FrameBits-1:0] frame;
  logic                unused_tx;

  // The final bit is taken straight from Mosi, so RX only stores FrameBits-1 bits.
  spi_shift_reg #(.Width(FrameBits - 1)) u_rx_sr (
    .clk   (clk),
    .rst   (rst),
    .clr   (rx_clr),
    .load  (rx_load),
    .din   ({{(FrameBits - 2){1'b0}}, Mosi}),
    .shift (rx_shift),
    .sin   (Mosi),
    .q     (rx_q)
  );

  spi_shift_reg #(.Width(BlkBits)) u_tx_sr (
    .clk   (clk),
    .rst   (rst),
    .clr   (tx_clr),
    .load  (tx_load),
    .din   (res_data),
    .shift (tx_shift),
    .sin   (1'b0),
    .q     (tx_q)
  );

  assign frame     = {rx_q, Mosi};
  assign unused_tx = ^tx_q[BlkBits-2:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    miso_d   = 1'b1;
    done_d   = 1'b0;
    ferr_d   = 1'b0;
    armed_d  = armed_q;
    msg_d    = msg_q;
    key_d    = key_q;
    rx_clr   = 1'b0;
    rx_load  = 1'b0;
    rx_shift = 1'b0;
    tx_clr   = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    case (state_q)
      StIdle: begin
        if (!cs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          rx_load = 1'b1;
          cnt_d   = CntW'(1);
          state_d = StRx;
        end
      end
      StRx: begin
        if (!cs) begin
          rx_clr  = 1'b1;
          cnt_d   = '0;
          ferr_d  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == CntW'(FrameBits - 1)) begin
          msg_d   = frame[FrameBits-1 -: BlkBits];
          key_d   = frame[KeyBits-1:0];
          rx_clr  = 1'b1;
          cnt_d   = '0;
          state_d = StHand;
        end else begin
          rx_shift = 1'b1;
          cnt_d    = cnt_q + CntW'(1);
        end
      end
      StHand: begin
        if (blk_ready) state_d = StWait;
      end
      StWait: begin
        if (res_valid) begin
          tx_load = 1'b1;
          miso_d  = 1'b0;
          cnt_d   = '0;
          state_d = StTx;
        end
      end
      StTx: begin
        if (!cs) begin
          tx_clr  = 1'b1;
          cnt_d   = '0;
          ferr_d  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == CntW'(BlkBits)) begin
          tx_clr  = 1'b1;
          cnt_d   = '0;
          done_d  = 1'b1;
          armed_d = 1'b0;
          state_d = StIdle;
        end else begin
          miso_d   = tx_q[BlkBits-1];
          tx_shift = 1'b1;
          cnt_d    = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      miso_q  <= 1'b1;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b1;
      msg_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
      msg_q   <= msg_d;
      key_q   <= key_d;
    end
  end

  assign Miso      = miso_q;
  assign blk_valid = (state_q == StHand);
  assign res_ready = (state_q == StWait);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign msg_out   = msg_q;
  assign key_out   = key_q;

endmodule

// File: tb/tb_aes_spi_slave.sv
// Directed bench for aes_spi_slave: vector table of full transactions plus abort/reset sequences.
module tb_aes_spi_slave;
  import aes_spi_pkg::*;

  localparam int unsigned BW = 32 * NB_DEFAULT;
  localparam int unsigned KW = 32 * NK_DEFAULT;

  logic          clk = 1'b0;
  logic          rst, cs, Mosi, Miso;
  logic          blk_valid, blk_ready, res_valid, res_ready, busy, done, frame_err;
  logic [BW-1:0] msg_out, res_data;
  logic [KW-1:0] key_out;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [BW-1:0] msg;
    logic [KW-1:0] key;
    logic [BW-1:0] res;
    int            ready_delay;
    bit            stray;
    logic [BW-1:0] exp_msg;
    logic [KW-1:0] exp_key;
    logic [BW-1:0] exp_tx;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  aes_spi_slave #(.nb(NB_DEFAULT), .nk(NK_DEFAULT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .Mosi      (Mosi),
    .Miso      (Miso),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .msg_out   (msg_out),
    .key_out   (key_out),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [FRAME_BITS-1:0] frame, input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      cs        = 1'b1;
      Mosi      = frame[FRAME_BITS-1-i];
      res_valid = stray && (i == 50);
      res_data  = {BW{1'b1}};
      tick();
    end
    res_valid = 1'b0;
    res_data  = '0;
  endtask

  task automatic do_txn(input vec_t v, input int rst_at_tx);
    logic [BW-1:0] got;
    bit            ok;
    got = '0;
    cs  = 1'b0;
    tick();
    send_bits({v.msg, v.key}, FRAME_BITS, v.stray);
    check("blk_valid_after_last_bit", blk_valid, 1'b1);
    check("msg_out", msg_out, v.exp_msg);
    check("key_out", key_out, v.exp_key);
    ok = 1'b1;
    for (int d = 0; d < v.ready_delay; d++) begin
      blk_ready = 1'b0;
      tick();
      if (blk_valid !== 1'b1 || msg_out !== v.exp_msg || key_out !== v.exp_key ||
          res_ready !== 1'b0) ok = 1'b0;
    end
    check("backpressure_stable", ok, 1'b1);
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    check("hand_done_blk_valid", blk_valid, 1'b0);
    check("wait_res_ready", res_ready, 1'b1);
    if (v.stray) begin
      blk_ready = 1'b1;
      tick();
      blk_ready = 1'b0;
      check("stray_ready_in_wait", {res_ready, blk_valid, Miso}, 3'b101);
    end
    res_data  = v.res;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    res_data  = '0;
    check("start_bit", Miso, 1'b0);
    check("tx_res_ready_low", res_ready, 1'b0);
    for (int i = 0; i < BW; i++) begin
      if (i == rst_at_tx) begin
        rst = 1'b0;
        tick();
        check("rst_tx_outputs", {Miso, busy, blk_valid, res_ready, done, frame_err}, 6'b100000);
        check("rst_tx_msg_key", {msg_out, key_out}, 256'h0);
        rst  = 1'b1;
        cs   = 1'b1;
        Mosi = 1'b1;
        tick();
        check("first_cycle_after_rst_starts", busy, 1'b1);
        cs = 1'b0;
        tick();
        check("abort_after_rst_ferr", {frame_err, busy}, 2'b10);
        return;
      end
      tick();
      got[BW-1-i] = Miso;
    end
    check("tx_data", got, v.exp_tx);
    check("no_done_before_end", done, 1'b0);
    tick();
    check("done_pulse", {done, Miso, busy}, 3'b110);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Mosi = 1'(i);
      tick();
      if (busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    check("cs_high_after_done_no_frame", ok, 1'b1);
  endtask

  initial begin
    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0,
                128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{{128{1'b1}}, 128'h0, {32{4'ha}}, 20, 1'b0,
                {128{1'b1}}, 128'h0, {32{4'ha}}};
    vecs[2] = '{128'h80000000000000000000000000000001, 128'h0123456789abcdeffedcba9876543210,
                128'h0, 3, 1'b1,
                128'h80000000000000000000000000000001, 128'h0123456789abcdeffedcba9876543210,
                128'h0};
    vecs[3] = '{128'h0, {128{1'b1}}, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, 1, 1'b0,
                128'h0, {128{1'b1}}, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f};

    rst       = 1'b0;
    cs        = 1'b0;
    Mosi      = 1'b0;
    blk_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    tick();
    tick();
    check("reset_outputs", {Miso, busy, blk_valid, res_ready, done, frame_err}, 6'b100000);
    check("reset_msg_key", {msg_out, key_out}, 256'h0);
    rst = 1'b1;
    tick();
    check("idle_after_reset", {busy, Miso}, 2'b01);

    for (int k = 0; k < 4; k++) do_txn(vecs[k], -1);

    // Abort mid-RX: msg_out must keep the last completed frame.
    cs = 1'b0;
    tick();
    send_bits({vecs[1].msg, vecs[1].key}, 101, 1'b0);
    check("rx_busy_before_abort", busy, 1'b1);
    cs = 1'b0;
    tick();
    check("abort_ferr_idle", {frame_err, busy, Miso}, 3'b101);
    check("abort_msg_unchanged", {msg_out, key_out}, {vecs[3].exp_msg, vecs[3].exp_key});
    tick();
    check("abort_ferr_one_cycle", frame_err, 1'b0);
    do_txn(vecs[0], -1);

    do_txn(vecs[1], 60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
